csb_to_periph: RTL and testbench



---
 rtl/csb_to_periph.sv | 196 +++++++++++++++++++
 tb/tb_csb_to_periph.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csb_to_periph.sv
// csb_to_periph: bridges one NVDLA CSB register access at a time onto a
// single-beat HWPE periph master port and returns read data or non-posted
// write completion on the CSB response channel.
module csb_to_periph #(
    parameter int unsigned          ID_WIDTH       = 1,
    parameter logic [ID_WIDTH-1:0]  PERIPH_ID      = '0,
    parameter logic [31:0]          BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned          TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,

    // CSB request channel
    input  logic                csb2nvdla_valid,
    output logic                csb2nvdla_ready,
    input  logic [15:0]         csb2nvdla_addr,
    input  logic [31:0]         csb2nvdla_wdat,
    input  logic                csb2nvdla_write,
    input  logic                csb2nvdla_nposted,

    // CSB response channel
    output logic                nvdla2csb_valid,
    output logic [31:0]         nvdla2csb_data,
    output logic                nvdla2csb_wr_complete,

    // periph master port
    output logic                periph_req_o,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic                periph_gnt_i,
    input  logic [31:0]         periph_r_data_i,
    input  logic                periph_r_valid_i,
    input  logic [ID_WIDTH-1:0] periph_r_id_i,

    output logic                timeout_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    // Last wait cycle index; reaching it without a response ends the access.
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic               req_q,     req_d;
    logic [ADDR_W-1:0]  add_q,     add_d;
    logic               wen_q,     wen_d;
    logic [DATA_W-1:0]  wdata_q,   wdata_d;
    logic               nposted_q, nposted_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               rvalid_q,  rvalid_d;
    logic [DATA_W-1:0]  rdata_q,   rdata_d;
    logic               wrc_q,     wrc_d;
    logic               tmo_q,     tmo_d;

    logic               accept_c;
    logic               rsp_hit_c;
    logic               expire_c;
    logic [ADDR_W-1:0]  xlat_addr_c;

    // Request handshake, matching response and timeout detection
    assign csb2nvdla_ready = (state_q == IDLE) & ~rst;
    assign accept_c        = csb2nvdla_valid & csb2nvdla_ready;
    assign rsp_hit_c       = (state_q == WAIT_R) & periph_r_valid_i
                           & (periph_r_id_i == PERIPH_ID);
    assign expire_c        = (state_q == WAIT_R) & ~rsp_hit_c & (cnt_q == CNT_LAST);

    // CSB word address to periph byte address, wrapping modulo 2^32
    assign xlat_addr_c     = BASE_ADDR + {14'b0, csb2nvdla_addr, 2'b00};

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)              state_d = REQ;
            REQ:     if (periph_gnt_i)          state_d = WAIT_R;
            WAIT_R:  if (rsp_hit_c | expire_c)  state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs and context
    always_comb begin
        req_d     = req_q;
        add_d     = add_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        nposted_d = nposted_q;
        cnt_d     = cnt_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        wrc_d     = 1'b0;
        tmo_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    req_d     = 1'b1;
                    add_d     = xlat_addr_c;
                    wen_d     = ~csb2nvdla_write;
                    wdata_d   = csb2nvdla_wdat;
                    nposted_d = csb2nvdla_nposted;
                end
            end
            REQ: begin
                if (periph_gnt_i) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                end
            end
            WAIT_R: begin
                if (rsp_hit_c) begin
                    if (wen_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = periph_r_data_i;
                    end else begin
                        wrc_d    = nposted_q;
                    end
                end else if (expire_c) begin
                    tmo_d = 1'b1;
                    if (wen_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = TIMEOUT_DATA;
                    end else begin
                        wrc_d    = nposted_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and transaction context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= 1'b0;
            add_q     <= '0;
            wen_q     <= 1'b1;
            wdata_q   <= '0;
            nposted_q <= 1'b0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            wrc_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            req_q     <= req_d;
            add_q     <= add_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            nposted_q <= nposted_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            wrc_q     <= wrc_d;
            tmo_q     <= tmo_d;
        end
    end

    assign periph_req_o          = req_q;
    assign periph_add_o          = add_q;
    assign periph_wen_o          = wen_q;
    assign periph_be_o           = 4'hF;
    assign periph_data_o         = wdata_q;
    assign periph_id_o           = PERIPH_ID;
    assign nvdla2csb_valid       = rvalid_q;
    assign nvdla2csb_data        = rdata_q;
    assign nvdla2csb_wr_complete = wrc_q;
    assign timeout_o             = tmo_q;

endmodule

// File: tb/tb_csb_to_periph.sv
// Directed bench for csb_to_periph: read, writes, back-to-back, grant stall,
// wrong-ID response, timeout and reset during a pending access.
module tb_csb_to_periph;

    logic        clk;
    logic        rst;
    logic        csb2nvdla_valid;
    logic        csb2nvdla_ready;
    logic [15:0] csb2nvdla_addr;
    logic [31:0] csb2nvdla_wdat;
    logic        csb2nvdla_write;
    logic        csb2nvdla_nposted;
    logic        nvdla2csb_valid;
    logic [31:0] nvdla2csb_data;
    logic        nvdla2csb_wr_complete;
    logic        periph_req_o;
    logic [31:0] periph_add_o;
    logic        periph_wen_o;
    logic [3:0]  periph_be_o;
    logic [31:0] periph_data_o;
    logic [1:0]  periph_id_o;
    logic        periph_gnt_i;
    logic [31:0] periph_r_data_i;
    logic        periph_r_valid_i;
    logic [1:0]  periph_r_id_i;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;
    int n;

    csb_to_periph #(
        .ID_WIDTH       (2),
        .PERIPH_ID      (2'd1),
        .BASE_ADDR      (32'h1000_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .csb2nvdla_valid       (csb2nvdla_valid),
        .csb2nvdla_ready       (csb2nvdla_ready),
        .csb2nvdla_addr        (csb2nvdla_addr),
        .csb2nvdla_wdat        (csb2nvdla_wdat),
        .csb2nvdla_write       (csb2nvdla_write),
        .csb2nvdla_nposted     (csb2nvdla_nposted),
        .nvdla2csb_valid       (nvdla2csb_valid),
        .nvdla2csb_data        (nvdla2csb_data),
        .nvdla2csb_wr_complete (nvdla2csb_wr_complete),
        .periph_req_o          (periph_req_o),
        .periph_add_o          (periph_add_o),
        .periph_wen_o          (periph_wen_o),
        .periph_be_o           (periph_be_o),
        .periph_data_o         (periph_data_o),
        .periph_id_o           (periph_id_o),
        .periph_gnt_i          (periph_gnt_i),
        .periph_r_data_i       (periph_r_data_i),
        .periph_r_valid_i      (periph_r_valid_i),
        .periph_r_id_i         (periph_r_id_i),
        .timeout_o             (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst               = 1'b1;
        csb2nvdla_valid   = 1'b0;
        csb2nvdla_addr    = 16'h0;
        csb2nvdla_wdat    = 32'h0;
        csb2nvdla_write   = 1'b0;
        csb2nvdla_nposted = 1'b0;
        periph_gnt_i      = 1'b0;
        periph_r_data_i   = 32'h0;
        periph_r_valid_i  = 1'b0;
        periph_r_id_i     = 2'd0;
        tick();
        tick();

        // reset values
        chk1 ("rst_ready",   csb2nvdla_ready, 1'b0);
        chk1 ("rst_valid",   nvdla2csb_valid, 1'b0);
        chk32("rst_data",    nvdla2csb_data, 32'h0);
        chk1 ("rst_wrc",     nvdla2csb_wr_complete, 1'b0);
        chk1 ("rst_req",     periph_req_o, 1'b0);
        chk32("rst_add",     periph_add_o, 32'h0);
        chk1 ("rst_wen",     periph_wen_o, 1'b1);
        chk32("rst_wdata",   periph_data_o, 32'h0);
        chk1 ("rst_timeout", timeout_o, 1'b0);
        chk32("rst_be",      32'(periph_be_o), 32'hF);
        chk32("rst_id",      32'(periph_id_o), 32'h1);
        rst = 1'b0;
        tick();
        chk1 ("idle_ready",  csb2nvdla_ready, 1'b1);

        // read: addr 0x0004 -> 0x1000_0010
        csb2nvdla_valid = 1'b1;
        csb2nvdla_addr  = 16'h0004;
        csb2nvdla_write = 1'b0;
        tick();
        csb2nvdla_valid = 1'b0;
        chk1 ("rd_req",      periph_req_o, 1'b1);
        chk32("rd_add",      periph_add_o, 32'h1000_0010);
        chk1 ("rd_wen",      periph_wen_o, 1'b1);
        chk32("rd_be",       32'(periph_be_o), 32'hF);
        chk1 ("rd_busy",     csb2nvdla_ready, 1'b0);
        periph_gnt_i = 1'b1;
        tick();
        periph_gnt_i = 1'b0;
        chk1 ("rd_req_drop", periph_req_o, 1'b0);
        periph_r_valid_i = 1'b1;
        periph_r_id_i    = 2'd1;
        periph_r_data_i  = 32'hCAFE_0001;
        tick();
        periph_r_valid_i = 1'b0;
        chk1 ("rd_valid",    nvdla2csb_valid, 1'b1);
        chk32("rd_data",     nvdla2csb_data, 32'hCAFE_0001);
        chk1 ("rd_ready",    csb2nvdla_ready, 1'b1);
        chk1 ("rd_no_wrc",   nvdla2csb_wr_complete, 1'b0);
        tick();
        chk1 ("rd_pulse",    nvdla2csb_valid, 1'b0);
        chk32("rd_hold",     nvdla2csb_data, 32'hCAFE_0001);

        // non-posted write: addr 0x0002 -> 0x1000_0008
        csb2nvdla_valid   = 1'b1;
        csb2nvdla_addr    = 16'h0002;
        csb2nvdla_wdat    = 32'h1234_5678;
        csb2nvdla_write   = 1'b1;
        csb2nvdla_nposted = 1'b1;
        tick();
        csb2nvdla_valid   = 1'b0;
        chk1 ("npw_req",     periph_req_o, 1'b1);
        chk32("npw_add",     periph_add_o, 32'h1000_0008);
        chk1 ("npw_wen",     periph_wen_o, 1'b0);
        chk32("npw_wdata",   periph_data_o, 32'h1234_5678);
        periph_gnt_i = 1'b1;
        tick();
        periph_gnt_i     = 1'b0;
        periph_r_valid_i = 1'b1;
        periph_r_data_i  = 32'h0000_0055;
        tick();
        periph_r_valid_i = 1'b0;
        chk1 ("npw_wrc",     nvdla2csb_wr_complete, 1'b1);
        chk1 ("npw_no_rd",   nvdla2csb_valid, 1'b0);
        chk32("npw_keep",    nvdla2csb_data, 32'hCAFE_0001);
        tick();
        chk1 ("npw_pulse",   nvdla2csb_wr_complete, 1'b0);

        // posted write addr 0x0010, then a read of 0xFFFF queued behind it
        csb2nvdla_valid   = 1'b1;
        csb2nvdla_addr    = 16'h0010;
        csb2nvdla_wdat    = 32'hAAAA_0000;
        csb2nvdla_write   = 1'b1;
        csb2nvdla_nposted = 1'b0;
        tick();
        chk32("pw_add",      periph_add_o, 32'h1000_0040);
        chk1 ("pw_wen",      periph_wen_o, 1'b0);
        csb2nvdla_addr  = 16'hFFFF;
        csb2nvdla_write = 1'b0;
        periph_gnt_i    = 1'b1;
        tick();
        periph_gnt_i     = 1'b0;
        chk1 ("pw_busy",     csb2nvdla_ready, 1'b0);
        periph_r_valid_i = 1'b1;
        tick();
        periph_r_valid_i = 1'b0;
        chk1 ("pw_ready",    csb2nvdla_ready, 1'b1);
        chk1 ("pw_no_rd",    nvdla2csb_valid, 1'b0);
        chk1 ("pw_no_wrc",   nvdla2csb_wr_complete, 1'b0);
        tick();
        csb2nvdla_valid = 1'b0;
        chk1 ("b2b_req",     periph_req_o, 1'b1);
        chk32("b2b_add",     periph_add_o, 32'h1003_FFFC);
        chk1 ("b2b_wen",     periph_wen_o, 1'b1);
        periph_gnt_i = 1'b1;
        tick();
        periph_gnt_i     = 1'b0;
        periph_r_valid_i = 1'b1;
        periph_r_data_i  = 32'hA5A5_5A5A;
        tick();
        periph_r_valid_i = 1'b0;
        chk1 ("b2b_valid",   nvdla2csb_valid, 1'b1);
        chk32("b2b_data",    nvdla2csb_data, 32'hA5A5_5A5A);
        tick();

        // grant stall of 5 cycles, then wrong-ID and right-ID responses
        csb2nvdla_valid = 1'b1;
        csb2nvdla_addr  = 16'h0001;
        csb2nvdla_write = 1'b0;
        tick();
        csb2nvdla_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1 ("stall_req", periph_req_o, 1'b1);
            chk32("stall_add", periph_add_o, 32'h1000_0004);
            tick();
        end
        chk1 ("stall_req5",  periph_req_o, 1'b1);
        chk32("stall_add5",  periph_add_o, 32'h1000_0004);
        periph_gnt_i = 1'b1;
        tick();
        periph_gnt_i     = 1'b0;
        chk1 ("stall_drop",  periph_req_o, 1'b0);
        periph_r_valid_i = 1'b1;
        periph_r_id_i    = 2'd0;
        periph_r_data_i  = 32'h0BAD_0BAD;
        tick();
        chk1 ("wid_ignored", nvdla2csb_valid, 1'b0);
        chk1 ("wid_busy",    csb2nvdla_ready, 1'b0);
        periph_r_id_i    = 2'd1;
        periph_r_data_i  = 32'h7777_1111;
        tick();
        periph_r_valid_i = 1'b0;
        chk1 ("rid_valid",   nvdla2csb_valid, 1'b1);
        chk32("rid_data",    nvdla2csb_data, 32'h7777_1111);
        chk1 ("rid_ready",   csb2nvdla_ready, 1'b1);
        tick();
        chk1 ("rid_single",  nvdla2csb_valid, 1'b0);

        // timeout on a read; response in the grant cycle must be ignored
        csb2nvdla_valid = 1'b1;
        csb2nvdla_addr  = 16'h0003;
        tick();
        csb2nvdla_valid  = 1'b0;
        periph_gnt_i     = 1'b1;
        periph_r_valid_i = 1'b1;
        periph_r_data_i  = 32'h1111_2222;
        tick();
        periph_gnt_i     = 1'b0;
        periph_r_valid_i = 1'b0;
        chk1 ("gnt_rsp_ign", nvdla2csb_valid, 1'b0);
        chk1 ("to_early",    timeout_o, 1'b0);
        n = 0;
        while (!timeout_o && n < 20) begin
            tick();
            n++;
        end
        chk32("to_latency",  32'(n), 32'd4);
        chk1 ("to_pulse",    timeout_o, 1'b1);
        chk1 ("to_valid",    nvdla2csb_valid, 1'b1);
        chk32("to_data",     nvdla2csb_data, 32'hDEAD_BEEF);
        chk1 ("to_ready",    csb2nvdla_ready, 1'b1);
        tick();
        chk1 ("to_one",      timeout_o, 1'b0);
        chk1 ("to_vone",     nvdla2csb_valid, 1'b0);

        // reset while waiting for a response
        csb2nvdla_valid = 1'b1;
        csb2nvdla_addr  = 16'h0005;
        tick();
        csb2nvdla_valid = 1'b0;
        periph_gnt_i    = 1'b1;
        tick();
        periph_gnt_i = 1'b0;
        chk1 ("mr_wait",     periph_req_o, 1'b0);
        chk32("mr_pre_add",  periph_add_o, 32'h1000_0014);
        rst = 1'b1;
        #1;
        chk1 ("mr_ready",    csb2nvdla_ready, 1'b0);
        chk1 ("mr_req",      periph_req_o, 1'b0);
        chk32("mr_add",      periph_add_o, 32'h0);
        chk1 ("mr_wen",      periph_wen_o, 1'b1);
        chk32("mr_wdata",    periph_data_o, 32'h0);
        chk32("mr_data",     nvdla2csb_data, 32'h0);
        chk1 ("mr_valid",    nvdla2csb_valid, 1'b0);
        rst              = 1'b0;
        periph_r_valid_i = 1'b1;
        periph_r_id_i    = 2'd1;
        periph_r_data_i  = 32'h9999_9999;
        tick();
        periph_r_valid_i = 1'b0;
        chk1 ("late_valid",  nvdla2csb_valid, 1'b0);
        chk1 ("late_wrc",    nvdla2csb_wr_complete, 1'b0);
        chk1 ("late_tmo",    timeout_o, 1'b0);
        chk1 ("late_req",    periph_req_o, 1'b0);
        chk1 ("late_ready",  csb2nvdla_ready, 1'b1);
        chk32("late_data",   nvdla2csb_data, 32'h0);
        tick();
        chk1 ("late_req2",   periph_req_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
